// File: rtl/ucpu_bus_pkg.sv
// ucpu_bus_pkg: destination map codes, default widths and read_bus state type shared across the bus blocks
package ucpu_bus_pkg;
  localparam int WRITE_BUS_WIDTH_D = 12;
  localparam int ADDR_WIDTH_D = 5;
  localparam int ALU_WIDTH_D = 8;
  localparam int RF_ADDR_WIDTH_D = 3;
  localparam int IMM_WIDTH_D = 11;
  localparam int BRANCH_ADDR_WIDTH_D = 10;
  localparam int PC_WIDTH_D = 10;
  localparam int RF_TIMEOUT_D = 15;
  localparam int A_MAP = 0;
  localparam int B_MAP = 1;
  localparam int REG_SEL_MAP = 5;
  localparam int REG_WR_DATA_MAP = 6;
  localparam int IMM_MAP = 8;
  localparam int BRANCH_TARGET_MAP = 11;
  localparam int M_PC_MAP = 12;
  typedef enum logic {IDLE, RF_WRITE} read_bus_state_t;
endpackage

// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: register-file write handshake FSM; optional ack timeout under READ_BUS_RF_TIMEOUT_EN
module rf_write_ctrl
  import ucpu_bus_pkg::*;
#(
  parameter int RF_TIMEOUT = RF_TIMEOUT_D
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rf_wr_ack,
  output logic rf_wr_en,
  output logic bus_ready,
  output logic timeout
);
  read_bus_state_t state, state_nx;
  logic hit;
`ifdef READ_BUS_RF_TIMEOUT_EN
  localparam int CW = $clog2(RF_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end
  assign hit = 32'(cnt) == RF_TIMEOUT - 1;
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // an ack arriving in the same cycle as the timeout takes priority
  always_comb begin
    state_nx = state;
    timeout = 1'b0;
    if (state == IDLE) state_nx = start ? RF_WRITE : IDLE;
    else if (rf_wr_ack) state_nx = IDLE;
    else if (hit) begin
      state_nx = IDLE;
      timeout = 1'b1;
    end
  end
  assign rf_wr_en = state == RF_WRITE;
  assign bus_ready = state == IDLE;
endmodule

// File: rtl/read_bus.sv
// read_bus: latches bus words into the register addressed by reg_dst; optional RF write timeout via READ_BUS_RF_TIMEOUT_EN
module read_bus
  import ucpu_bus_pkg::*;
#(
  parameter int WRITE_BUS_WIDTH = WRITE_BUS_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int ALU_WIDTH = ALU_WIDTH_D,
  parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_D,
  parameter int IMM_WIDTH = IMM_WIDTH_D,
  parameter int BRANCH_ADDR_WIDTH = BRANCH_ADDR_WIDTH_D,
  parameter int PC_WIDTH = PC_WIDTH_D,
  parameter int RF_TIMEOUT = RF_TIMEOUT_D
) (
  input  logic clk,
  input  logic rst,
  input  logic [ADDR_WIDTH-1:0] reg_dst,
  input  logic [WRITE_BUS_WIDTH-1:0] bus_in,
  input  logic bus_valid,
  output logic bus_ready,
  output logic [ALU_WIDTH-1:0] a_reg,
  output logic [ALU_WIDTH-1:0] b_reg,
  output logic [RF_ADDR_WIDTH-1:0] reg_sel,
  output logic [ALU_WIDTH-1:0] reg_wr_data,
  output logic rf_wr_en,
  input  logic rf_wr_ack,
  output logic [IMM_WIDTH-1:0] imm_reg,
  output logic [BRANCH_ADDR_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] m_pc,
  output logic pc_load,
  output logic dst_err
);
  logic [31:0] code;
  logic xfer, legal, timeout;
  assign code = 32'(reg_dst);
  assign xfer = bus_valid && bus_ready;
  assign legal = code inside {A_MAP, B_MAP, REG_SEL_MAP, REG_WR_DATA_MAP, IMM_MAP, BRANCH_TARGET_MAP, M_PC_MAP};
  rf_write_ctrl #(.RF_TIMEOUT(RF_TIMEOUT)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .start(xfer && code == REG_WR_DATA_MAP),
    .rf_wr_ack(rf_wr_ack),
    .rf_wr_en(rf_wr_en),
    .bus_ready(bus_ready),
    .timeout(timeout)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      reg_sel <= '0;
      reg_wr_data <= '0;
      imm_reg <= '0;
      branch_target <= '0;
      m_pc <= '0;
      pc_load <= 1'b0;
      dst_err <= 1'b0;
    end else begin
      pc_load <= xfer && code == M_PC_MAP;
      dst_err <= dst_err || (xfer && !legal) || timeout;
      if (xfer && code == A_MAP) a_reg <= bus_in[ALU_WIDTH-1:0];
      if (xfer && code == B_MAP) b_reg <= bus_in[ALU_WIDTH-1:0];
      if (xfer && code == REG_SEL_MAP) reg_sel <= bus_in[RF_ADDR_WIDTH-1:0];
      if (xfer && code == REG_WR_DATA_MAP) reg_wr_data <= bus_in[ALU_WIDTH-1:0];
      if (xfer && code == IMM_MAP) imm_reg <= bus_in[IMM_WIDTH-1:0];
      if (xfer && code == BRANCH_TARGET_MAP) branch_target <= bus_in[BRANCH_ADDR_WIDTH-1:0];
      if (xfer && code == M_PC_MAP) m_pc <= bus_in[PC_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_read_bus.sv
// tb_read_bus: directed stimulus, per-cycle comparison against a behavioural register-map model
module tb_read_bus;
  localparam int TO = 4;
  logic clk = 0, rst = 1;
  logic [4:0] reg_dst = 0;
  logic [11:0] bus_in = 0;
  logic bus_valid = 0, rf_wr_ack = 0;
  logic bus_ready, rf_wr_en, pc_load, dst_err;
  logic [7:0] a_reg, b_reg, reg_wr_data;
  logic [2:0] reg_sel;
  logic [10:0] imm_reg;
  logic [9:0] branch_target, m_pc;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  read_bus #(.RF_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .reg_dst(reg_dst), .bus_in(bus_in), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .a_reg(a_reg), .b_reg(b_reg), .reg_sel(reg_sel),
    .reg_wr_data(reg_wr_data), .rf_wr_en(rf_wr_en), .rf_wr_ack(rf_wr_ack),
    .imm_reg(imm_reg), .branch_target(branch_target), .m_pc(m_pc),
    .pc_load(pc_load), .dst_err(dst_err)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  // model: registers indexed by map code, plus a pending-write flag and wait count
  logic [11:0] mreg [0:12];
  bit pend, merr, mpcl, started;
  int wait_n;
  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      for (int i = 0; i <= 12; i++) mreg[i] = 0;
      pend = 0; merr = 0; mpcl = 0; wait_n = 0;
    end else begin
      mpcl = 0;
      if (pend) begin
        if (rf_wr_ack) pend = 0;
`ifdef READ_BUS_RF_TIMEOUT_EN
        else if (wait_n == TO - 1) begin pend = 0; merr = 1; end
`endif
        else wait_n++;
      end else if (bus_valid) begin
        case (int'(reg_dst))
          0, 1, 6: mreg[reg_dst] = {4'h0, bus_in[7:0]};
          5: mreg[5] = {9'h0, bus_in[2:0]};
          8: mreg[8] = {1'b0, bus_in[10:0]};
          11, 12: mreg[reg_dst] = {2'h0, bus_in[9:0]};
          default: merr = 1;
        endcase
        if (reg_dst == 6) begin pend = 1; wait_n = 0; end
        if (reg_dst == 12) mpcl = 1;
      end
    end
  end
  always @(negedge clk) if (started) begin
    chk("a_reg", 32'(a_reg), 32'(mreg[0]));
    chk("b_reg", 32'(b_reg), 32'(mreg[1]));
    chk("reg_sel", 32'(reg_sel), 32'(mreg[5]));
    chk("reg_wr_data", 32'(reg_wr_data), 32'(mreg[6]));
    chk("imm_reg", 32'(imm_reg), 32'(mreg[8]));
    chk("branch_target", 32'(branch_target), 32'(mreg[11]));
    chk("m_pc", 32'(m_pc), 32'(mreg[12]));
    chk("pc_load", 32'(pc_load), 32'(mpcl));
    chk("dst_err", 32'(dst_err), 32'(merr));
    chk("rf_wr_en", 32'(rf_wr_en), 32'(pend));
    chk("bus_ready", 32'(bus_ready), 32'(!pend));
  end
  task automatic xfer(input logic [4:0] d, input logic [11:0] b);
    reg_dst = d; bus_in = b; bus_valid = 1;
    @(negedge clk);
    bus_valid = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_ready", 32'(bus_ready), 1);
    chk("rst_a", 32'(a_reg), 0);
    chk("rst_pc", 32'(m_pc), 0);
    chk("rst_err", 32'(dst_err), 0);
    xfer(0, 12'hABC);
    chk("a_trunc", 32'(a_reg), 32'h BC);
    xfer(12, 12'h7FF);
    chk("pc_trunc", 32'(m_pc), 32'h3FF);
    chk("pc_load_hi", 32'(pc_load), 1);
    @(negedge clk);
    chk("pc_load_lo", 32'(pc_load), 0);
    xfer(1, 12'h123);
    xfer(8, 12'hFFF);
    xfer(11, 12'hC01);
    chk("b_val", 32'(b_reg), 32'h23);
    chk("imm_val", 32'(imm_reg), 32'h7FF);
    chk("bt_val", 32'(branch_target), 32'h001);
    rf_wr_ack = 1;
    @(negedge clk);
    rf_wr_ack = 0;
    chk("idle_ack_ready", 32'(bus_ready), 1);
    reg_dst = 5; bus_in = 12'h003; bus_valid = 1;
    @(negedge clk);
    reg_dst = 6; bus_in = 12'h05A;
    @(negedge clk);
    reg_dst = 0; bus_in = 12'h011;
    for (int i = 0; i < 3; i++) begin
      chk("wr_en_wait", 32'(rf_wr_en), 1);
      chk("ready_wait", 32'(bus_ready), 0);
      chk("sel_hold", 32'(reg_sel), 3);
      chk("data_hold", 32'(reg_wr_data), 32'h5A);
      @(negedge clk);
      if (i == 1) bus_valid = 0;
    end
    rf_wr_ack = 1;
    chk("wr_en_4th", 32'(rf_wr_en), 1);
    @(negedge clk);
    rf_wr_ack = 0;
    chk("wr_en_done", 32'(rf_wr_en), 0);
    chk("ready_done", 32'(bus_ready), 1);
    chk("a_not_taken", 32'(a_reg), 32'h BC);
    xfer(2, 12'hFFF);
    chk("illegal_err", 32'(dst_err), 1);
    chk("illegal_a", 32'(a_reg), 32'h BC);
    xfer(13, 12'h000);
    xfer(0, 12'h044);
    chk("err_sticky", 32'(dst_err), 1);
    chk("a_after_err", 32'(a_reg), 32'h44);
    do_reset();
    chk("err_cleared", 32'(dst_err), 0);
    xfer(6, 12'h077);
    chk("rst_wr_en_hi", 32'(rf_wr_en), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_wr_en_lo", 32'(rf_wr_en), 0);
    chk("rst_ready_hi", 32'(bus_ready), 1);
    @(negedge clk);
`ifdef READ_BUS_RF_TIMEOUT_EN
    xfer(6, 12'h022);
    for (int i = 0; i < TO; i++) begin
      chk("to_wr_en", 32'(rf_wr_en), 1);
      @(negedge clk);
    end
    chk("to_abort", 32'(rf_wr_en), 0);
    chk("to_err", 32'(dst_err), 1);
    do_reset();
    xfer(6, 12'h033);
    repeat (TO - 1) @(negedge clk);
    rf_wr_ack = 1;
    @(negedge clk);
    rf_wr_ack = 0;
    chk("to_ack_done", 32'(rf_wr_en), 0);
    chk("to_ack_noerr", 32'(dst_err), 0);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
